mole_gen: RTL and testbench
===========================

Name: mole_gen

Overview:
- Mole spawner for the whack-a-mole game core.
- Drives the 18 mole LEDs and judges player switch presses against the lit mole.
- Emits single-cycle hit, miss and timeout events; the score counter and display stage downstream consume these.
- Sits between the game timer/speed-select logic and the score/seven-segment stage.

Parameters:
- MS_DIV, 50000: clock cycles per 1 ms tick (50 MHz clock).
- DWELL_L1_MS, 1000: time a mole stays lit at speed level 1.
- DWELL_L2_MS, 700: time a mole stays lit at speed level 2.
- DWELL_L3_MS, 400: time a mole stays lit at speed level 3.
- GAP_MS, 100: dark time between moles.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- game_active  input  1  high while the round timer is running.
- speed_level  input  2  1/2/3 select dwell; 0 is treated as 1.
- switches  input  18  player switches, already synchronised to clk.
- leds  output  18  one-hot lit mole, or all zero.
- mole_idx  output  5  index 0..17 of the current or last mole.
- hit_pulse  output  1  one cycle on a correct hit.
- miss_pulse  output  1  one cycle on a wrong-switch press.
- timeout_pulse  output  1  one cycle when a mole expires unhit.

Behaviour:
- Reset, asynchronous:
  - leds=0, mole_idx=0, all pulses 0.
  - state=IDLE, lfsr=LFSR_SEED.
  - switch history sw_q=0, prescaler and ms counter = 0.
- Edge detect: rise = switches & ~sw_q. sw_q <= switches every cycle in all states.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle, including IDLE.
- Prescaler: counts 0..MS_DIV-1 and emits ms_tick at MS_DIV-1. Prescaler and ms counter both clear on every state transition.
- IDLE:
  - leds=0.
  - Press edges ignored; no miss is reported.
  - If game_active=1, go to GAP.
- GAP:
  - leds=0; press edges ignored.
  - After GAP_MS ticks (exactly GAP_MS*MS_DIV cycles in GAP), go to UP.
  - On leaving GAP, form cand = lfsr[4:0], minus 18 if cand >= 18.
  - If cand equals the previous mole_idx, use (cand+1) mod 18 instead.
  - Register the result as mole_idx.
  - Latch dwell from speed_level at this moment. A speed change mid-mole takes effect on the next mole.
- UP:
  - leds = 1 << mole_idx, registered, valid from the first UP cycle.
  - Priority per cycle, highest first:
    - game_active=0 -> IDLE, leds=0, no pulse.
    - rise[mole_idx]=1 -> hit_pulse=1 next cycle, GAP, leds=0 next cycle. Any other rising bit in the same cycle is ignored: no miss.
    - rise has only non-target bits -> miss_pulse=1 next cycle, stay UP, dwell counter unaffected. Several wrong bits in one cycle give one miss pulse.
    - Dwell expired (DWELL ms counted) -> timeout_pulse=1 next cycle, GAP.
  - A hit on the same cycle as expiry counts as a hit, not a timeout.
- game_active=0 in any state: IDLE on the next cycle.
- Pulses are registered and never last more than one cycle. At most one of hit/miss/timeout is asserted per cycle.
- A switch held high produces no further events; only a 0->1 transition counts.
- Reset mid-mole: leds drop immediately (asynchronous) and no pulse is emitted.
- Width rules: ms counter is 10 bits (max 1000). Dwell values are compared at full width.

Test Plan:
All scenarios use MS_DIV=10, DWELL_L1_MS=5, DWELL_L2_MS=3, DWELL_L3_MS=2, GAP_MS=2.
- Reset then game_active=1, speed_level=2:
  - leds=0 for 20 cycles of GAP.
  - Then exactly one led bit set for 30 cycles.
  - timeout_pulse for 1 cycle, leds=0.
- Mole lit at idx k, switches[k] rises mid-UP:
  - Next cycle: hit_pulse=1, leds=0.
  - No miss_pulse and no timeout_pulse for that mole.
- Mole lit at k, switches[(k+3)%18] rises:
  - miss_pulse=1 once, leds unchanged.
  - Timeout still occurs 30 cycles after UP entry.
  - Then raise switches[k] in the same cycle as a wrong bit: hit_pulse only.
- switches[k] rises on the exact expiry cycle: hit_pulse=1, timeout_pulse stays 0.
- game_active dropped mid-UP:
  - leds=0 next cycle, no pulses.
  - Switch presses in IDLE give no miss_pulse.
  - Reasserting game_active restarts with a 20-cycle GAP.
- 200 consecutive moles with timeouts only:
  - mole_idx always in 0..17 and never equal to the previous idx.
  - leds always one-hot in UP.
  - With speed_level=0, UP lasts 50 cycles, the level 1 dwell.

Source files
------------

// File: rtl/mole_gen.sv
// Mole spawner: lights one of 18 mole LEDs after a dark gap and judges switch
// presses against it, emitting single-cycle hit, miss and timeout events.
`timescale 1ns/1ps
module mole_gen #(
  parameter int unsigned MS_DIV      = 50000,
  parameter int unsigned DWELL_L1_MS = 1000,
  parameter int unsigned DWELL_L2_MS = 700,
  parameter int unsigned DWELL_L3_MS = 400,
  parameter int unsigned GAP_MS      = 100,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_active,
  input  logic [1:0]  speed_level,
  input  logic [17:0] switches,
  output logic [17:0] leds,
  output logic [4:0]  mole_idx,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic        timeout_pulse
);

  localparam int unsigned NUM_MOLES = 18;
  localparam int unsigned IW        = 5;
  localparam int unsigned MW        = 10;
  localparam int unsigned PW        = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  typedef enum logic [1:0] {IDLE, GAP, UP} state_t;

  state_t                 state, state_d;
  logic [PW-1:0]          pre_q;
  logic [MW-1:0]          ms_q;
  logic [MW-1:0]          dwell_q, dwell_d, dwell_sel;
  logic [15:0]            lfsr_q;
  logic [NUM_MOLES-1:0]   sw_q, rise;
  logic [NUM_MOLES-1:0]   leds_d;
  logic [IW-1:0]          idx_d, cand_m, cand;
  logic                   hit_d, miss_d, timeout_d;
  logic                   ms_tick, gap_done, dwell_done, target_hit, wrong_press;
  logic [MW:0]            ms_next;

  // Datapath helpers: edges, ms timebase, candidate mole and dwell selection
  always_comb begin
    rise        = switches & ~sw_q;
    target_hit  = |(rise & leds);
    wrong_press = |(rise & ~leds);
    ms_tick     = (pre_q == PW'(MS_DIV - 1));
    ms_next     = {1'b0, ms_q} + (MW+1)'(1);
    gap_done    = ms_tick && (ms_next == (MW+1)'(GAP_MS));
    dwell_done  = ms_tick && (ms_next == {1'b0, dwell_q});
    cand_m      = (lfsr_q[4:0] >= IW'(NUM_MOLES)) ? lfsr_q[4:0] - IW'(NUM_MOLES) : lfsr_q[4:0];
    if (cand_m == mole_idx) cand = (cand_m == IW'(NUM_MOLES - 1)) ? IW'(0) : cand_m + IW'(1);
    else                    cand = cand_m;
    case (speed_level)
      2'd2:    dwell_sel = MW'(DWELL_L2_MS);
      2'd3:    dwell_sel = MW'(DWELL_L3_MS);
      default: dwell_sel = MW'(DWELL_L1_MS);
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    leds_d    = leds;
    idx_d     = mole_idx;
    dwell_d   = dwell_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        leds_d = '0;
        if (game_active) state_d = GAP;
      end
      GAP: begin
        leds_d = '0;
        if (!game_active) begin
          state_d = IDLE;
        end else if (gap_done) begin
          state_d = UP;
          idx_d   = cand;
          leds_d  = NUM_MOLES'(1) << cand;
          dwell_d = dwell_sel;
        end
      end
      UP: begin
        if (!game_active) begin
          state_d = IDLE;
          leds_d  = '0;
        end else if (target_hit) begin
          hit_d   = 1'b1;
          state_d = GAP;
          leds_d  = '0;
        end else if (wrong_press) begin
          miss_d  = 1'b1;
        end else if (dwell_done) begin
          timeout_d = 1'b1;
          state_d   = GAP;
          leds_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        leds_d  = '0;
      end
    endcase
  end

  // State, outputs and switch history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      leds          <= '0;
      mole_idx      <= '0;
      dwell_q       <= '0;
      hit_pulse     <= 1'b0;
      miss_pulse    <= 1'b0;
      timeout_pulse <= 1'b0;
      sw_q          <= '0;
    end else begin
      state         <= state_d;
      leds          <= leds_d;
      mole_idx      <= idx_d;
      dwell_q       <= dwell_d;
      hit_pulse     <= hit_d;
      miss_pulse    <= miss_d;
      timeout_pulse <= timeout_d;
      sw_q          <= switches;
    end
  end

  // Free-running LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // ms timebase restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (state_d != state) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (ms_tick) begin
      pre_q <= '0;
      ms_q  <= ms_q + MW'(1);
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_mole_gen.sv
// Scoreboard bench for mole_gen: stimulus queues expected events, a negedge
// monitor matches pulses, mole indices, LED patterns and gap/dwell lengths.
`timescale 1ns/1ps
module tb_mole_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int K_HIT = 0;
  localparam int K_MISS = 1;
  localparam int K_TO = 2;

  typedef struct { int kind; int up; } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_active = 1'b0;
  logic [1:0]  speed_level = 2'd0;
  logic [17:0] switches = '0;
  logic [17:0] leds;
  logic [4:0]  mole_idx;
  logic        hit_pulse, miss_pulse, timeout_pulse;

  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];

  logic [15:0] m_lfsr, m_prev;
  int   m_last = 0;
  int   gap_len = 0;
  int   up_len = 0;
  bit   lit_prev = 0;
  bit   ga_prev = 0;
  int   k;

  always #5 clk = ~clk;

  mole_gen #(
    .MS_DIV(10), .DWELL_L1_MS(5), .DWELL_L2_MS(3), .DWELL_L3_MS(2),
    .GAP_MS(2), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_active(game_active), .speed_level(speed_level),
    .switches(switches), .leds(leds), .mole_idx(mole_idx), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .timeout_pulse(timeout_pulse)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR, one step per clock like the game core
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  // Monitor: samples on the falling edge
  always @(negedge clk) begin
    int cand, n;
    ev_t e;
    if (!rst_n) begin
      lit_prev = 0;
      ga_prev  = 0;
      gap_len  = 0;
      up_len   = 0;
      m_last   = 0;
    end else begin
      n = int'(hit_pulse) + int'(miss_pulse) + int'(timeout_pulse);
      if (n > 1) chk("pulse_exclusive", n, 1);
      if (leds != 0) begin
        if (!lit_prev) begin
          cand = int'(m_prev[4:0]);
          if (cand >= 18) cand -= 18;
          if (cand == m_last) cand = (cand == 17) ? 0 : cand + 1;
          chk("mole_idx", int'(mole_idx), cand);
          chk("idx_not_repeated", int'(int'(mole_idx) != m_last), 1);
          chk("gap_cycles", gap_len, 20);
          m_last = cand;
          up_len = 0;
        end
        up_len++;
        chk("leds_onehot", int'(leds), int'(18'(1) << m_last));
      end else begin
        if (lit_prev || (game_active && !ga_prev)) gap_len = 1;
        else gap_len++;
      end
      if (n != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse_hms", {29'd0, hit_pulse, miss_pulse, timeout_pulse}, 0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", hit_pulse ? K_HIT : (miss_pulse ? K_MISS : K_TO), e.kind);
          if (e.kind == K_TO && timeout_pulse) chk("up_cycles", up_len, e.up);
          if (!miss_pulse) chk("pulse_idx", int'(mole_idx), m_last);
        end
      end
      lit_prev = (leds != 0);
      ga_prev  = game_active;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_mole();
    int n = 0;
    while (leds == 0 && n < 300) begin
      step(1);
      n++;
    end
    chk("wait_mole_lit", int'(leds != 0), 1);
  endtask

  task automatic wait_dark();
    int n = 0;
    while (leds != 0 && n < 300) begin
      step(1);
      n++;
    end
    chk("wait_dark", int'(leds == 0), 1);
  endtask

  task automatic push(input int kind, input int up);
    sb.push_back('{kind, up});
  endtask

  initial begin
    step(3);
    chk("reset_leds", int'(leds), 0);
    chk("reset_idx", int'(mole_idx), 0);
    chk("reset_pulses", {29'd0, hit_pulse, miss_pulse, timeout_pulse}, 0);
    rst_n = 1'b1;
    game_active = 1'b1;
    speed_level = 2'd2;

    // First mole times out after 30 cycles
    wait_mole();
    push(K_TO, 30);
    wait_dark();

    // Hit mid-UP
    wait_mole();
    k = m_last;
    step(5);
    switches = 18'(1) << k;
    push(K_HIT, 0);
    step(1);
    chk("hit_leds_off", int'(leds), 0);
    switches = '0;

    // Wrong switch held: one miss, then timeout at 30
    wait_mole();
    k = m_last;
    step(5);
    switches = 18'(1) << ((k + 3) % 18);
    push(K_MISS, 0);
    step(1);
    chk("miss_leds_held", int'(leds), int'(18'(1) << k));
    step(9);
    switches = '0;
    push(K_TO, 30);
    wait_dark();

    // Target and wrong bit together: hit only
    wait_mole();
    k = m_last;
    step(4);
    switches = (18'(1) << k) | (18'(1) << ((k + 5) % 18));
    push(K_HIT, 0);
    step(1);
    chk("combo_leds_off", int'(leds), 0);
    switches = '0;

    // Hit on the expiry cycle
    wait_mole();
    k = m_last;
    step(29);
    switches = 18'(1) << k;
    push(K_HIT, 0);
    step(1);
    chk("expiry_hit_leds_off", int'(leds), 0);
    switches = '0;

    // Drop game_active mid-UP; presses in IDLE are ignored
    wait_mole();
    step(10);
    game_active = 1'b0;
    step(1);
    chk("drop_leds_off", int'(leds), 0);
    switches = 18'h3FFFF;
    step(3);
    switches = '0;
    step(3);
    switches = 18'h00005;
    step(2);
    switches = '0;
    step(2);
    chk("idle_dark", int'(leds), 0);
    game_active = 1'b1;

    // Speed change mid-mole applies to the next mole
    wait_mole();
    speed_level = 2'd3;
    push(K_TO, 30);
    wait_dark();
    wait_mole();
    push(K_TO, 20);
    speed_level = 2'd0;
    wait_dark();

    // 200 timeouts at level 0 (level 1 dwell)
    for (int i = 0; i < 200; i++) begin
      wait_mole();
      push(K_TO, 50);
      wait_dark();
    end

    // Reset mid-mole
    wait_mole();
    step(5);
    rst_n = 1'b0;
    #1;
    chk("rst_leds_async", int'(leds), 0);
    chk("rst_pulses", {29'd0, hit_pulse, miss_pulse, timeout_pulse}, 0);
    step(2);
    chk("rst_idx", int'(mole_idx), 0);
    rst_n = 1'b1;
    wait_mole();
    push(K_TO, 50);
    wait_dark();

    game_active = 1'b0;
    step(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
